// File: rtl/antares_mem_access_unit.sv
// MEM-stage data-port access unit: big-endian lane steering, load formatting,
// address checks, LL/SC reservation and bus timeout behind a stall handshake.
module antares_mem_access_unit #(
  parameter int BUS_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_alu_result,
  input  logic [31:0] mem_mem_store_data,
  input  logic        mem_mem_write,
  input  logic        mem_mem_to_gpr_select,
  input  logic        mem_mem_byte,
  input  logic        mem_mem_halfword,
  input  logic        mem_mem_data_sign_ext,
  input  logic        mem_llsc,
  input  logic        mem_kernel_mode,
  input  logic        mem_flush,
  input  logic        mem_eret,
  input  logic [31:0] dport_data_i,
  input  logic        dport_ready,
  input  logic        dport_error,
  output logic [31:0] dport_address,
  output logic [31:0] dport_data_o,
  output logic [3:0]  dport_wr,
  output logic        dport_enable,
  output logic [31:0] mem_read_data,
  output logic        mem_request_stall,
  output logic        exc_address_if_load,
  output logic        exc_address_if_store,
  output logic        mem_bus_error
);

  localparam int CW = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT + 1) : 1;
  localparam int TO_LAST_I = (BUS_TIMEOUT > 0) ? BUS_TIMEOUT - 1 : 0;
  localparam logic [CW-1:0] TO_LAST = CW'(TO_LAST_I);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t        state_r;
  logic          llbit_r;
  logic [29:0]   lladdr_r;
  logic [CW-1:0] cnt_r;
  logic          flushed_r, is_load_r, llsc_r, byte_r, half_r, sext_r;
  logic [1:0]    addr_lo_r;

  logic          op_s, addr_err_s, sc_ok_s, timeout_s, complete_s, err_s, killed_s;
  logic [3:0]    wr_s;
  logic [31:0]   wdata_s, ldata_s;
  logic [7:0]    lane_b_s;
  logic [15:0]   lane_h_s;

  assign op_s       = (mem_mem_write | mem_mem_to_gpr_select) & ~mem_flush;
  assign addr_err_s = (~mem_mem_byte & mem_mem_halfword & mem_alu_result[0])
                    | (~mem_mem_byte & ~mem_mem_halfword & (mem_alu_result[1:0] != 2'b00))
                    | (mem_alu_result[31] & ~mem_kernel_mode);
  assign sc_ok_s    = llbit_r & (lladdr_r == mem_alu_result[31:2]);
  assign timeout_s  = (BUS_TIMEOUT != 0) & (cnt_r == TO_LAST) & ~dport_ready;
  assign complete_s = dport_ready | timeout_s;
  assign err_s      = (dport_ready & dport_error) | timeout_s;
  assign killed_s   = flushed_r | mem_flush;

  // Address exceptions and the pipeline hold request; both forced low in reset.
  always_comb begin
    exc_address_if_load  = rst & op_s & ~mem_mem_write & addr_err_s;
    exc_address_if_store = rst & op_s & mem_mem_write & addr_err_s;
    case (state_r)
      ST_IDLE: mem_request_stall = rst & op_s & ~addr_err_s;
      ST_BUSY: mem_request_stall = rst;
      default: mem_request_stall = 1'b0;
    endcase
  end

  // Store byte enables and replicated data; byte lane 0 is bits [31:24].
  always_comb begin
    wr_s    = 4'b1111;
    wdata_s = mem_mem_store_data;
    if (mem_mem_byte) begin
      wdata_s = {4{mem_mem_store_data[7:0]}};
      case (mem_alu_result[1:0])
        2'b00:   wr_s = 4'b1000;
        2'b01:   wr_s = 4'b0100;
        2'b10:   wr_s = 4'b0010;
        default: wr_s = 4'b0001;
      endcase
    end else if (mem_mem_halfword) begin
      wdata_s = {2{mem_mem_store_data[15:0]}};
      wr_s    = mem_alu_result[1] ? 4'b0011 : 4'b1100;
    end else begin
      wr_s    = 4'b1111;
    end
  end

  // Load lane select and extension from the access captured at issue.
  always_comb begin
    case (addr_lo_r)
      2'b00:   lane_b_s = dport_data_i[31:24];
      2'b01:   lane_b_s = dport_data_i[23:16];
      2'b10:   lane_b_s = dport_data_i[15:8];
      default: lane_b_s = dport_data_i[7:0];
    endcase
    lane_h_s = addr_lo_r[1] ? dport_data_i[15:0] : dport_data_i[31:16];
    if (byte_r) begin
      ldata_s = {{24{sext_r & lane_b_s[7]}}, lane_b_s};
    end else if (half_r) begin
      ldata_s = {{16{sext_r & lane_h_s[15]}}, lane_h_s};
    end else begin
      ldata_s = dport_data_i;
    end
  end

  // Transaction FSM; a flushed op still waits out the bus but skips DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r       <= ST_IDLE;
      dport_address <= 32'd0;
      dport_data_o  <= 32'd0;
      dport_wr      <= 4'b0000;
      dport_enable  <= 1'b0;
      mem_read_data <= 32'd0;
      mem_bus_error <= 1'b0;
      cnt_r         <= '0;
      flushed_r     <= 1'b0;
      is_load_r     <= 1'b0;
      llsc_r        <= 1'b0;
      byte_r        <= 1'b0;
      half_r        <= 1'b0;
      sext_r        <= 1'b0;
      addr_lo_r     <= 2'b00;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (op_s && !addr_err_s) begin
            if (mem_mem_write && mem_llsc && !sc_ok_s) begin
              mem_read_data <= 32'd0;
              state_r       <= ST_DONE;
            end else begin
              dport_enable  <= 1'b1;
              dport_address <= {mem_alu_result[31:2], 2'b00};
              dport_wr      <= mem_mem_write ? wr_s : 4'b0000;
              dport_data_o  <= wdata_s;
              cnt_r         <= '0;
              flushed_r     <= 1'b0;
              is_load_r     <= ~mem_mem_write;
              llsc_r        <= mem_llsc;
              byte_r        <= mem_mem_byte;
              half_r        <= mem_mem_halfword;
              sext_r        <= mem_mem_data_sign_ext;
              addr_lo_r     <= mem_alu_result[1:0];
              state_r       <= ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          cnt_r     <= cnt_r + CW'(1);
          flushed_r <= killed_s;
          if (complete_s) begin
            dport_enable <= 1'b0;
            if (killed_s) begin
              state_r <= ST_IDLE;
            end else begin
              state_r <= ST_DONE;
              if (err_s) begin
                mem_bus_error <= 1'b1;
                mem_read_data <= 32'd0;
              end else if (is_load_r) begin
                mem_read_data <= ldata_s;
              end else if (llsc_r) begin
                mem_read_data <= 32'd1;
              end
            end
          end
        end
        ST_DONE: begin
          mem_bus_error <= 1'b0;
          state_r       <= ST_IDLE;
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // LL/SC reservation; an ERET clear overrides a coincident LL completion.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      llbit_r  <= 1'b0;
      lladdr_r <= 30'd0;
    end else if (mem_eret) begin
      llbit_r <= 1'b0;
    end else if (state_r == ST_BUSY && complete_s && !killed_s && llsc_r) begin
      if (!is_load_r) begin
        llbit_r <= 1'b0;
      end else if (!err_s) begin
        llbit_r  <= 1'b1;
        lladdr_r <= dport_address[31:2];
      end
    end
  end

endmodule

// File: tb/tb_antares_mem_access_unit.sv
// Randomized bench for antares_mem_access_unit against a transaction-level
// model of lane steering, load formatting, LL/SC and timeout outcomes.
module tb_antares_mem_access_unit;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mem_alu_result, mem_mem_store_data, dport_data_i;
  logic        mem_mem_write, mem_mem_to_gpr_select, mem_mem_byte, mem_mem_halfword;
  logic        mem_mem_data_sign_ext, mem_llsc, mem_kernel_mode, mem_flush, mem_eret;
  logic        dport_ready, dport_error;
  logic [31:0] dport_address, dport_data_o, mem_read_data;
  logic [3:0]  dport_wr;
  logic        dport_enable, mem_request_stall, exc_address_if_load, exc_address_if_store;
  logic        mem_bus_error;

  int n_vec = 0;
  int n_bad = 0;

  logic        llbit_m;
  logic [29:0] lladdr_m;
  logic [31:0] rd_m;

  antares_mem_access_unit #(.BUS_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .mem_alu_result(mem_alu_result), .mem_mem_store_data(mem_mem_store_data),
    .mem_mem_write(mem_mem_write), .mem_mem_to_gpr_select(mem_mem_to_gpr_select),
    .mem_mem_byte(mem_mem_byte), .mem_mem_halfword(mem_mem_halfword),
    .mem_mem_data_sign_ext(mem_mem_data_sign_ext), .mem_llsc(mem_llsc),
    .mem_kernel_mode(mem_kernel_mode), .mem_flush(mem_flush), .mem_eret(mem_eret),
    .dport_data_i(dport_data_i), .dport_ready(dport_ready), .dport_error(dport_error),
    .dport_address(dport_address), .dport_data_o(dport_data_o), .dport_wr(dport_wr),
    .dport_enable(dport_enable), .mem_read_data(mem_read_data),
    .mem_request_stall(mem_request_stall), .exc_address_if_load(exc_address_if_load),
    .exc_address_if_store(exc_address_if_store), .mem_bus_error(mem_bus_error)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    mem_alu_result = 32'd0; mem_mem_store_data = 32'd0; mem_mem_write = 1'b0;
    mem_mem_to_gpr_select = 1'b0; mem_mem_byte = 1'b0; mem_mem_halfword = 1'b0;
    mem_mem_data_sign_ext = 1'b0; mem_llsc = 1'b0; mem_kernel_mode = 1'b0;
    mem_flush = 1'b0; mem_eret = 1'b0; dport_ready = 1'b0; dport_error = 1'b0;
    dport_data_i = 32'd0;
  endtask

  task automatic idle_cycle(input bit eret);
    @(negedge clk);
    clear_inputs();
    mem_eret = eret;
    #1;
    check_value("idle_stall", {31'd0, mem_request_stall}, 32'd0);
    if (eret) llbit_m = 1'b0;
  endtask

  // size: 0 byte, 1 halfword, 2 word; lat 0 = ready never comes; flush_at = BUSY cycle index
  task automatic run_op(input bit st, input int size, input bit sext, input bit llsc,
                        input logic [31:0] addr, input logic [31:0] sdata, input bit kmode,
                        input int lat, input logic [31:0] rdata, input bit berr,
                        input int flush_at, input bit flush_idle, input bit both);
    bit aerr, sc_fail, flushed, terr, exp_err, done;
    int exp_busy, busy, cyc, sh;
    logic [3:0]  exp_wr;
    logic [31:0] exp_do, ld;
    aerr = (size == 1 && addr[0]) || (size == 2 && addr[1:0] != 2'b00) || (addr[31] && !kmode);
    @(negedge clk);
    clear_inputs();
    mem_alu_result = addr; mem_mem_store_data = sdata; mem_mem_write = st;
    mem_mem_to_gpr_select = !st || both; mem_mem_byte = (size == 0);
    mem_mem_halfword = (size == 1); mem_mem_data_sign_ext = sext; mem_llsc = llsc;
    mem_kernel_mode = kmode; mem_flush = flush_idle;
    #1;
    check_value("berr_idle", {31'd0, mem_bus_error}, 32'd0);
    check_value("exc_ld", {31'd0, exc_address_if_load}, {31'd0, !flush_idle && !st && aerr});
    check_value("exc_st", {31'd0, exc_address_if_store}, {31'd0, !flush_idle && st && aerr});
    if (flush_idle || aerr) begin
      check_value("stall_none", {31'd0, mem_request_stall}, 32'd0);
      @(posedge clk); #1;
      check_value("no_issue", {31'd0, dport_enable}, 32'd0);
      clear_inputs();
      return;
    end
    // expected bus image
    if (!st) exp_wr = 4'b0000;
    else if (size == 0) exp_wr = 4'b1000 >> addr[1:0];
    else if (size == 1) exp_wr = addr[1] ? 4'b0011 : 4'b1100;
    else exp_wr = 4'b1111;
    if (size == 0) exp_do = {24'd0, sdata[7:0]} * 32'h0101_0101;
    else if (size == 1) exp_do = {16'd0, sdata[15:0]} * 32'h0001_0001;
    else exp_do = sdata;
    // expected formatted load
    if (size == 0) begin
      sh = 8 * (3 - int'(addr[1:0]));
      ld = (rdata >> sh) & 32'h0000_00FF;
      if (sext && ld[7]) ld = ld | 32'hFFFF_FF00;
    end else if (size == 1) begin
      sh = 16 * (1 - int'(addr[1]));
      ld = (rdata >> sh) & 32'h0000_FFFF;
      if (sext && ld[15]) ld = ld | 32'hFFFF_0000;
    end else begin
      ld = rdata;
    end
    sc_fail  = st && llsc && !(llbit_m && lladdr_m == addr[31:2]);
    terr     = (lat == 0) || (lat > TO);
    exp_busy = sc_fail ? 0 : (terr ? TO : lat);
    flushed  = !sc_fail && flush_at != 0;
    exp_err  = 1'b0;
    if (sc_fail) begin
      rd_m = 32'd0;
    end else if (!flushed) begin
      exp_err = terr || berr;
      if (exp_err) rd_m = 32'd0;
      else if (!st) rd_m = ld;
      else if (llsc) rd_m = 32'd1;
      if (st && llsc) llbit_m = 1'b0;
      else if (!st && llsc && !exp_err) begin
        llbit_m = 1'b1; lladdr_m = addr[31:2];
      end
    end
    busy = 0; cyc = 0; done = 1'b0;
    while (!done && cyc < 40) begin
      cyc++;
      if (dport_enable) begin
        busy++;
        check_value("dp_addr", dport_address, addr & 32'hFFFF_FFFC);
        check_value("dp_wr", {28'd0, dport_wr}, {28'd0, exp_wr});
        check_value("dp_data", dport_data_o, exp_do);
        dport_ready  = (busy == lat);
        dport_error  = berr && (busy == lat);
        dport_data_i = (busy == lat) ? rdata : $urandom;
        if (busy == flush_at) begin
          mem_flush = 1'b1; mem_mem_write = 1'b0; mem_mem_to_gpr_select = 1'b0; mem_llsc = 1'b0;
        end else begin
          mem_flush = 1'b0;
        end
      end else begin
        dport_ready = 1'b0; dport_error = 1'b0; mem_flush = 1'b0;
      end
      #1;
      if (!mem_request_stall) done = 1'b1;
      else begin
        @(negedge clk); #1;
      end
    end
    check_value("latency", cyc, exp_busy + 2);
    check_value("busy_cycles", busy, exp_busy);
    check_value("read_data", mem_read_data, rd_m);
    check_value("bus_err", {31'd0, mem_bus_error}, {31'd0, exp_err});
  endtask

  initial begin
    bit st, sext, llsc, mis, kmode, berr, both;
    int size, lat, flush_at, ebusy;
    logic [31:0] base, addr;
    logic [1:0]  off;

    clear_inputs();
    llbit_m = 1'b0; lladdr_m = 30'd0; rd_m = 32'd0;
    rst = 1'b1;
    #2 rst = 1'b0;
    #10;
    check_value("rst_addr", dport_address, 32'd0);
    check_value("rst_data", dport_data_o, 32'd0);
    check_value("rst_wr", {28'd0, dport_wr}, 32'd0);
    check_value("rst_en", {31'd0, dport_enable}, 32'd0);
    check_value("rst_rd", mem_read_data, 32'd0);
    check_value("rst_stall", {31'd0, mem_request_stall}, 32'd0);
    check_value("rst_berr", {31'd0, mem_bus_error}, 32'd0);
    @(negedge clk) rst = 1'b1;

    // directed scenarios
    run_op(1, 0, 0, 0, 32'h0000_1001, 32'h0000_00AB, 1, 2, 32'd0, 0, 0, 0, 0);
    run_op(0, 0, 1, 0, 32'h0000_2003, 32'd0, 1, 1, 32'h1122_33F0, 0, 0, 0, 0);
    check_value("lb_sext", mem_read_data, 32'hFFFF_FFF0);
    run_op(0, 0, 0, 0, 32'h0000_2003, 32'd0, 1, 1, 32'h1122_33F0, 0, 0, 0, 0);
    check_value("lb_zext", mem_read_data, 32'h0000_00F0);
    run_op(0, 2, 0, 0, 32'h0000_2002, 32'd0, 1, 1, 32'd0, 0, 0, 0, 0);
    run_op(1, 2, 0, 0, 32'h8000_0000, 32'h1234_5678, 0, 1, 32'd0, 0, 0, 0, 0);
    run_op(0, 2, 0, 1, 32'h0000_3000, 32'd0, 1, 1, 32'h5555_AAAA, 0, 0, 0, 0);
    run_op(1, 2, 0, 1, 32'h0000_3000, 32'h0000_0007, 1, 1, 32'd0, 0, 0, 0, 0);
    check_value("sc_ok", mem_read_data, 32'd1);
    run_op(1, 2, 0, 1, 32'h0000_3000, 32'h0000_0007, 1, 1, 32'd0, 0, 0, 0, 0);
    check_value("sc_again", mem_read_data, 32'd0);
    run_op(0, 2, 0, 1, 32'h0000_3000, 32'd0, 1, 2, 32'h0BAD_F00D, 0, 0, 0, 0);
    idle_cycle(1);
    run_op(1, 2, 0, 1, 32'h0000_3000, 32'h0000_0007, 1, 1, 32'd0, 0, 0, 0, 0);
    check_value("sc_after_eret", mem_read_data, 32'd0);
    run_op(0, 2, 0, 0, 32'h0000_3004, 32'd0, 1, 0, 32'd0, 0, 0, 0, 0);
    run_op(0, 2, 0, 0, 32'h0000_3008, 32'd0, 1, 1, 32'hCAFE_BABE, 0, 0, 0, 0);
    run_op(0, 2, 0, 0, 32'h0000_300C, 32'd0, 1, 3, 32'h1357_9BDF, 0, 2, 0, 0);
    check_value("flush_keep", mem_read_data, 32'hCAFE_BABE);
    run_op(0, 2, 0, 0, 32'h0000_3010, 32'd0, 1, 1, 32'h1111_2222, 0, 0, 1, 0);
    run_op(1, 1, 0, 0, 32'h0000_3012, 32'h0000_BEEF, 1, 1, 32'd0, 0, 0, 0, 1);
    run_op(0, 1, 1, 0, 32'h0000_3016, 32'd0, 1, 2, 32'h0000_8001, 1, 0, 0, 0);

    // asynchronous reset in the middle of a bus transaction
    @(negedge clk);
    clear_inputs();
    mem_alu_result = 32'h0000_4000; mem_mem_to_gpr_select = 1'b1; mem_kernel_mode = 1'b1;
    @(negedge clk); #1;
    check_value("busy_en", {31'd0, dport_enable}, 32'd1);
    rst = 1'b0;
    #1;
    check_value("rst_mid_en", {31'd0, dport_enable}, 32'd0);
    check_value("rst_mid_stall", {31'd0, mem_request_stall}, 32'd0);
    clear_inputs();
    llbit_m = 1'b0; rd_m = 32'd0;
    @(negedge clk) rst = 1'b1;

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      st    = 1'($urandom_range(0, 1));
      size  = $urandom_range(0, 2);
      sext  = 1'($urandom_range(0, 1));
      llsc  = ($urandom_range(0, 3) == 0);
      if (llsc) size = 2;
      base  = ($urandom_range(0, 3) == 0) ? $urandom : 32'h0000_3000 + 32'(4 * $urandom_range(0, 3));
      mis   = ($urandom_range(0, 5) == 0);
      off   = 2'($urandom_range(0, 3));
      if (!mis && size == 1) off[0] = 1'b0;
      if (!mis && size == 2) off = 2'b00;
      addr  = {base[31:2], off};
      kmode = ($urandom_range(0, 3) != 0);
      lat   = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 4);
      ebusy = (lat == 0) ? TO : lat;
      berr  = ($urandom_range(0, 7) == 0);
      flush_at = ($urandom_range(0, 7) == 0) ? $urandom_range(1, ebusy) : 0;
      both  = st && ($urandom_range(0, 3) == 0);
      run_op(st, size, sext, llsc, addr, $urandom, kmode, lat, $urandom, berr, flush_at,
             ($urandom_range(0, 19) == 0), both);
      if ($urandom_range(0, 9) == 0) idle_cycle(1'($urandom_range(0, 1)));
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/antares_mem_access_unit.md
Name: antares_mem_access_unit

Overview:
MEM-stage consumer of the EX->MEM pipeline register outputs. It turns the registered memory-control signals into data-port transactions with a request/ready handshake, and returns formatted load data. It handles byte-lane steering (big-endian), sign/zero extension, address-error detection, LL/SC reservation and bus timeout. It raises a stall request to hold the pipeline while a transaction is outstanding.

Parameters:
BUS_TIMEOUT, 16, cycles in BUSY without dport_ready before a bus error is forced; 0 disables the timeout.

Ports:
clk  input  1  main clock
rst  input  1  main reset, asynchronous, active-low
mem_alu_result  input  32  effective address
mem_mem_store_data  input  32  store data, right-aligned
mem_mem_write  input  1  store operation
mem_mem_to_gpr_select  input  1  load operation
mem_mem_byte  input  1  byte access
mem_mem_halfword  input  1  halfword access
mem_mem_data_sign_ext  input  1  sign-extend load data
mem_llsc  input  1  LL (with load) / SC (with store)
mem_kernel_mode  input  1  kernel privilege
mem_flush  input  1  kill the current MEM op
mem_eret  input  1  clear LL reservation
dport_data_i  input  32  read data from bus
dport_ready  input  1  transaction complete
dport_error  input  1  bus error, valid with ready
dport_address  output  32  word-aligned address, bits [1:0]=0
dport_data_o  output  32  lane-steered store data
dport_wr  output  4  byte write enables, bit3=bits[31:24]
dport_enable  output  1  request valid
mem_read_data  output  32  formatted load / SC result
mem_request_stall  output  1  hold pipeline
exc_address_if_load  output  1  load address error (combinational)
exc_address_if_store  output  1  store address error (combinational)
mem_bus_error  output  1  one-cycle bus error pulse

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; all outputs 0; llbit=0; lladdr=0; timeout counter=0.
- op = (mem_mem_write | mem_mem_to_gpr_select) & ~mem_flush. If both write and load are asserted, write wins.
- Address error (combinational, no transaction, no stall):
  - halfword access with addr[0]=1;
  - word access with addr[1:0]≠0;
  - addr[31]=1 with mem_kernel_mode=0.
  - Routed to exc_address_if_load or exc_address_if_store according to the op type.
- Store lanes (big-endian):
  - byte at addr[1:0]=00/01/10/11 -> wr 1000/0100/0010/0001; data byte replicated on all four lanes;
  - halfword at addr[1]=0/1 -> wr 1100/0011; data halfword replicated on both halves;
  - word -> wr 1111.
- Load: select the lane by the same mapping; sign-extend if mem_mem_data_sign_ext, otherwise zero-extend.
- FSM IDLE:
  - valid op with no address error: mem_request_stall=1 (combinational).
  - SC with (llbit=0 or lladdr≠addr[31:2]): no bus access; mem_read_data<=0; ->DONE.
  - Otherwise register dport_enable<=1, address, wr (0000 for loads) and data; clear counter; ->BUSY.
- FSM BUSY:
  - mem_request_stall=1; dport_* held stable; counter increments each cycle.
  - On dport_ready:
    - dport_enable<=0;
    - load: mem_read_data<=formatted data; LL sets llbit<=1, lladdr<=addr[31:2];
    - SC: mem_read_data<=1, llbit<=0;
    - dport_error: mem_bus_error<=1, mem_read_data<=0;
    - ->DONE.
  - Counter reaching BUST_TIMEOUT (BUS_TIMEOUT≠0): treated as ready+error, dport_enable<=0.
- FSM DONE: mem_request_stall=0 (pipeline advances this cycle); mem_bus_error clears next cycle; ->IDLE.
- Minimum latency: 2 cycles (SC fail). A bus op whose ready arrives in the first BUSY cycle takes 3 cycles.
- mem_flush while BUSY: the transaction cannot be cancelled. Wait for ready/timeout, discard data, leave llbit unchanged, suppress mem_bus_error, go directly to IDLE. mem_request_stall stays 1 until then.
- mem_flush in IDLE: no issue, no stall.
- mem_eret clears llbit in any state. If it coincides with an LL completion, the clear wins.
- mem_read_data holds its value outside DONE-producing events.

Test Plan:
- Reset: assert rst=0 mid-BUSY -> dport_enable=0, state IDLE, mem_request_stall=0 immediately.
- SB 0xAB to 0x1001 -> dport_address=0x1000, wr=0100, data_o=0xABABABAB; stall high for IDLE+BUSY, low in DONE; ready after 2 BUSY cycles -> 4 cycles total.
- LB at 0x2003, dport_data_i=0x112233F0, sign_ext=1 -> mem_read_data=0xFFFFFFF0; same with sign_ext=0 -> 0x000000F0.
- LW at 0x2002 -> exc_address_if_load=1, no dport_enable, no stall. SW at 0x80000000 in user mode -> exc_address_if_store=1.
- LL 0x3000, then SC 0x3000 -> write issued, mem_read_data=1. Second SC -> no bus access, mem_read_data=0. LL then mem_eret then SC -> 0.
- BUS_TIMEOUT=4, ready never asserted -> after 4 BUSY cycles mem_bus_error=1 for one cycle. Flush during a BUSY load with ready at cycle 3 -> no DONE, no error, mem_read_data unchanged.
